// File: rtl/data_mem_responder_pkg.sv
// Shared types and defaults for the data-memory responder.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Matches the instruction-memory base so both sides share one address map.
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// Single-port synchronous word RAM with per-byte write strobes.
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wmask,
  output logic [31:0]       rdata
);

  // One byte-wide array per lane so each strobe owns its storage outright.
  for (genvar b = 0; b < 4; b++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];
    logic [7:0] lane_q;

    // Lane write on strobe, registered read on request; read data holds otherwise.
    always_ff @(posedge clk) begin
      if (we && wmask[b]) begin
        lane_mem[idx] <= wdata[8*b +: 8];
      end
      if (re) begin
        lane_q <= lane_mem[idx];
      end
    end

    assign rdata[8*b +: 8] = lane_q;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle responder for the NPC data-memory interface.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned       LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wmask,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int unsigned       IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0]   SPAN_BYTES = (ADDR_W+1)'(DEPTH_WORDS * 4);

  state_t            state;
  logic [3:0]        cnt;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wmask_q;
  logic              rdata_sel;

  logic              accept;
  logic              access;
  logic              src_wen;
  logic [ADDR_W-1:0] src_addr;
  logic [31:0]       src_wdata;
  logic [3:0]        src_wmask;
  logic [ADDR_W-1:0] offset;
  logic              fault;
  logic [IDX_W-1:0]  idx;
  logic              ram_we;
  logic              ram_re;
  logic [31:0]       ram_rdata;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // Access source and decode: with zero latency the RAM is hit on the
  // acceptance edge itself, so the live request is used in IDLE.
  always_comb begin
    src_wen   = wen_q;
    src_addr  = addr_q;
    src_wdata = wdata_q;
    src_wmask = wmask_q;
    if (state == IDLE) begin
      src_wen   = req_wen;
      src_addr  = req_addr;
      src_wdata = req_wdata;
      src_wmask = req_wmask;
    end
    offset = src_addr - BASE_ADDR;
    fault  = ({1'b0, offset} >= SPAN_BYTES) || (src_addr[1:0] != 2'b00);
    idx    = offset[IDX_W+1:2];
    access = !rst && (((state == IDLE) && accept && (LATENCY == 0)) ||
                      ((state == WAIT) && (cnt == 4'd1)));
    ram_we = access && src_wen && !fault;
    ram_re = access && !src_wen && !fault;
  end

  // Capture request fields on the handshake; they need not stay stable after.
  always_ff @(posedge clk) begin
    if (accept) begin
      wen_q   <= req_wen;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wmask_q <= req_wmask;
    end
  end

  // Request FSM with wait-state counter and registered response flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      rdata_sel  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          if (accept) begin
            cnt   <= 4'(LATENCY);
            state <= WAIT;
          end
        end
        WAIT: cnt <= cnt - 4'd1;
        RESP: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Both IDLE (zero latency) and WAIT enter RESP on the access edge; this
      // later assignment overrides the per-state next-state above.
      if (access) begin
        state      <= RESP;
        resp_valid <= 1'b1;
        resp_err   <= fault;
        rdata_sel  <= !src_wen && !fault;
      end
    end
  end

  assign resp_rdata = rdata_sel ? ram_rdata : '0;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .idx  (idx),
    .wdata(src_wdata),
    .wmask(src_wmask),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder at LATENCY=2 and LATENCY=0.
module tb_data_mem_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_wen    [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [3:0]  req_wmask  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int n_cmp = 0;
  int n_err = 0;

  // Reference memory: one word array per instance, 1024 words each.
  logic [31:0] mdl [2][1024];

  data_mem_responder #(
    .ADDR_W(32), .DEPTH_WORDS(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(2)
  ) dut_l2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wen(req_wen[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  data_mem_responder #(
    .ADDR_W(32), .DEPTH_WORDS(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(0)
  ) dut_l0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wen(req_wen[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  function automatic int lat(input int s);
    return (s == 0) ? 2 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural outcome of one request, applied to the reference memory.
  task automatic model_access(input int s, input bit wen, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] wmask,
                              output logic err, output logic [31:0] rd);
    logic [31:0] off;
    int unsigned w;
    off = addr - BASE;
    err = (off >= 32'd4096) || (addr % 4 != 0);
    rd  = '0;
    if (!err) begin
      w = off / 4;
      if (wen) begin
        for (int b = 0; b < 4; b++)
          if (wmask[b]) mdl[s][w][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        rd = mdl[s][w];
      end
    end
  endtask

  task automatic do_req(input int s, input bit wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask,
                        output logic [31:0] rd, output logic er);
    int k;
    bit seen;
    logic exp_err;
    logic [31:0] exp_rd;
    @(negedge clk);
    check("ready_before", req_ready[s], 1'b1);
    req_valid[s] = 1'b1;
    req_wen[s]   = wen;
    req_addr[s]  = addr;
    req_wdata[s] = wdata;
    req_wmask[s] = wmask;
    model_access(s, wen, addr, wdata, wmask, exp_err, exp_rd);
    @(negedge clk);
    req_valid[s] = 1'b0;
    req_wen[s]   = 1'($urandom);
    req_addr[s]  = $urandom;
    req_wdata[s] = $urandom;
    req_wmask[s] = 4'($urandom);
    k = 1;
    seen = 1'b0;
    while (!seen && k <= 20) begin
      if (resp_valid[s]) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    check("resp_latency", seen ? k : 99, lat(s) + 1);
    rd = resp_rdata[s];
    er = resp_err[s];
    check("resp_err", er, exp_err);
    check("resp_rdata", rd, exp_rd);
    @(negedge clk);
    check("resp_pulse", resp_valid[s], 1'b0);
    check("ready_after", req_ready[s], 1'b1);
  endtask

  // req_valid held high; fields change only in cycles where ready is seen.
  task automatic back_to_back(input int s);
    int acc_t[$];
    int rsp_t[$];
    logic [31:0] exp_q[$];
    logic [31:0] addrs[3];
    int issued;
    logic e;
    logic [31:0] r;
    addrs[0] = BASE + 32'h0;
    addrs[1] = BASE + 32'h14;
    addrs[2] = BASE + 32'h24;
    issued = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (resp_valid[s]) begin
        rsp_t.push_back(n);
        if (exp_q.size() > 0) check("b2b_rdata", resp_rdata[s], exp_q.pop_front());
        else check("b2b_extra_resp", 1'b1, 1'b0);
      end
      if (req_ready[s]) begin
        if (issued < 3) begin
          req_valid[s] = 1'b1;
          req_wen[s]   = 1'b0;
          req_addr[s]  = addrs[issued];
          model_access(s, 1'b0, addrs[issued], 32'h0, 4'h0, e, r);
          exp_q.push_back(r);
          acc_t.push_back(n);
          issued++;
        end else begin
          req_valid[s] = 1'b0;
        end
      end
    end
    req_valid[s] = 1'b0;
    check("b2b_count", rsp_t.size(), 3);
    if (rsp_t.size() == 3 && acc_t.size() == 3) begin
      for (int i = 0; i < 3; i++) check("b2b_latency", rsp_t[i] - acc_t[i], lat(s) + 1);
      for (int i = 1; i < 3; i++) check("b2b_spacing", rsp_t[i] - rsp_t[i-1], lat(s) + 2);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    logic [31:0] a;
    int sel;

    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_wen[s] = 1'b0; req_addr[s] = '0;
      req_wdata[s] = '0;   req_wmask[s] = '0;
    end

    // Reset and idle behaviour.
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("rst_ready", req_ready[s], 1'b0);
      check("rst_resp_valid", resp_valid[s], 1'b0);
      check("rst_rdata", resp_rdata[s], 32'h0);
      check("rst_err", resp_err[s], 1'b0);
    end
    rst = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) check("ready_after_rst", req_ready[s], 1'b1);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) check("idle_resp_valid", resp_valid[s], 1'b0);
    end

    // Give the first 16 words of each instance known contents.
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 16; w++)
        do_req(s, 1'b1, BASE + 32'(4 * w), $urandom, 4'hF, rd, er);

    // Directed sequence at LATENCY=2.
    do_req(0, 1'b1, 32'h8000_0010, 32'hDEADBEEF, 4'hF, rd, er);
    check("store_err", er, 1'b0);
    do_req(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er);
    check("load_full", rd, 32'hDEADBEEF);
    do_req(0, 1'b1, 32'h8000_0010, 32'h11223344, 4'b0101, rd, er);
    do_req(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er);
    check("load_partial", rd, 32'hDE22BE44);
    do_req(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, rd, er);
    check("below_base_err", er, 1'b1);
    check("below_base_rdata", rd, 32'h0);
    do_req(0, 1'b0, 32'h8000_1000, 32'h0, 4'h0, rd, er);
    check("above_top_err", er, 1'b1);
    do_req(0, 1'b1, 32'h8000_0012, 32'hFFFF_FFFF, 4'hF, rd, er);
    check("misaligned_err", er, 1'b1);
    do_req(0, 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, rd, er);
    check("mask0_err", er, 1'b0);
    do_req(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er);
    check("reload_unchanged", rd, 32'hDE22BE44);
    do_req(1, 1'b1, 32'h8000_0010, 32'hCAFE_0001, 4'hF, rd, er);
    do_req(1, 1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er);
    check("l0_load", rd, 32'hCAFE_0001);

    back_to_back(0);
    back_to_back(1);

    // Reset while a LATENCY=2 store is in WAIT: no response, no write.
    @(negedge clk);
    req_valid[0] = 1'b1; req_wen[0] = 1'b1; req_addr[0] = BASE + 32'h20;
    req_wdata[0] = 32'h5A5A_5A5A; req_wmask[0] = 4'hF;
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("midrst_ready", req_ready[0], 1'b0);
      check("midrst_resp_valid", resp_valid[0], 1'b0);
    end
    rst = 1'b0;
    #1;
    check("midrst_ready_after", req_ready[0], 1'b1);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("midrst_no_resp", resp_valid[0], 1'b0);
    end
    do_req(0, 1'b0, BASE + 32'h20, 32'h0, 4'h0, rd, er);

    // Randomized traffic against the reference model.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 60; i++) begin
        sel = $urandom_range(0, 9);
        if (sel < 7)       a = BASE + 32'(4 * $urandom_range(0, 15));
        else if (sel == 7) a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
        else if (sel == 8) a = BASE - 32'(4 * $urandom_range(1, 100));
        else               a = BASE + 32'd4096 + 32'(4 * $urandom_range(0, 1000));
        do_req(s, 1'($urandom), a, $urandom, 4'($urandom), rd, er);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
